// File: rtl/alu_dispatch.sv
// RV32I ALU operand/op decode feeding a 2-entry skid buffer toward the ALU.
// Latency: 1 cycle from input transfer to out_valid when the output stage is empty or draining.
// Backpressure: in_ready is registered and drops the cycle after the skid register fills.
module alu_dispatch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [3:0]  out_op,
  output logic        out_illegal,
  output logic [2:0]  out_funct3,
  output logic [15:0] issue_count
);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        illegal;
    logic [2:0]  funct3;
  } meta_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_ILL  = 4'd15;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;
  logic [3:0]  alu_op;
  logic        bad;
  meta_t       dec_dat;

  assign opc   = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign f7    = in_instr[31:25];
  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_u = {in_instr[31:12], 12'h000};

  // funct3 -> op for the register/immediate ALU groups (shift variants resolved below)
  always_comb begin
    alu_op = OP_ADD;
    case (f3)
      3'b000: alu_op = OP_ADD;
      3'b001: alu_op = OP_SLL;
      3'b010: alu_op = OP_SLT;
      3'b011: alu_op = OP_SLTU;
      3'b100: alu_op = OP_XOR;
      3'b101: alu_op = OP_SRL;
      3'b110: alu_op = OP_OR;
      default: alu_op = OP_AND;
    endcase
  end

  always_comb begin
    dec_dat        = '0;
    dec_dat.funct3 = f3;
    bad            = 1'b0;
    case (opc)
      7'b0110011: begin
        dec_dat.a = in_rs1;
        dec_dat.b = in_rs2;
        if (f7 == 7'b0000000)
          dec_dat.op = alu_op;
        else if (f7 == 7'b0100000 && f3 == 3'b000)
          dec_dat.op = OP_SUB;
        else if (f7 == 7'b0100000 && f3 == 3'b101)
          dec_dat.op = OP_SRA;
        else
          bad = 1'b1;
      end
      7'b0010011: begin
        dec_dat.a  = in_rs1;
        dec_dat.b  = imm_i;
        dec_dat.op = alu_op;
        if (f3 == 3'b001 && f7 != 7'b0000000)
          bad = 1'b1;
        else if (f3 == 3'b101) begin
          if (f7 == 7'b0100000)
            dec_dat.op = OP_SRA;
          else if (f7 != 7'b0000000)
            bad = 1'b1;
        end
      end
      7'b1100011: begin
        dec_dat.a = in_rs1;
        dec_dat.b = in_rs2;
        case (f3[2:1])
          2'b00:   dec_dat.op = OP_SUB;
          2'b10:   dec_dat.op = OP_SLT;
          2'b11:   dec_dat.op = OP_SLTU;
          default: bad = 1'b1;
        endcase
      end
      7'b0000011: begin
        dec_dat.a = in_rs1;
        dec_dat.b = imm_i;
      end
      7'b0100011: begin
        dec_dat.a = in_rs1;
        dec_dat.b = imm_s;
      end
      7'b0110111: dec_dat.b = imm_u;
      7'b0010111: begin
        dec_dat.a = in_pc;
        dec_dat.b = imm_u;
      end
      default: bad = 1'b1;
    endcase
    // Every illegal form presents the same clean marker with zeroed operands.
    if (bad) begin
      dec_dat.a       = '0;
      dec_dat.b       = '0;
      dec_dat.op      = OP_ILL;
      dec_dat.illegal = 1'b1;
    end
  end

  meta_t       out_q;
  meta_t       skid_q;
  logic        out_vld_q;
  logic        skid_vld_q;
  logic        in_rdy_q;
  logic [15:0] cnt_q;
  logic        in_xfer;
  logic        out_xfer;

  assign in_xfer  = in_valid & in_rdy_q;
  assign out_xfer = out_vld_q & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      in_rdy_q   <= 1'b0;
      cnt_q      <= '0;
    end else if (flush) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      in_rdy_q   <= 1'b1;
    end else begin
      if (out_xfer)
        cnt_q <= cnt_q + 16'd1;
      if (!out_vld_q || out_ready) begin
        // in_ready is low whenever the skid is full, so no new entry can arrive alongside the refill
        if (skid_vld_q) begin
          out_q      <= skid_q;
          out_vld_q  <= 1'b1;
          skid_vld_q <= 1'b0;
        end else begin
          out_vld_q <= in_xfer;
          if (in_xfer)
            out_q <= dec_dat;
        end
        in_rdy_q <= 1'b1;
      end else if (in_xfer) begin
        skid_q     <= dec_dat;
        skid_vld_q <= 1'b1;
        in_rdy_q   <= 1'b0;
      end else begin
        in_rdy_q <= ~skid_vld_q;
      end
    end
  end

  assign in_ready    = in_rdy_q;
  assign out_valid   = out_vld_q;
  assign out_a       = out_q.a;
  assign out_b       = out_q.b;
  assign out_op      = out_q.op;
  assign out_illegal = out_q.illegal;
  assign out_funct3  = out_q.funct3;
  assign issue_count = cnt_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Randomized and directed bench for alu_dispatch with a queue scoreboard and reference decoder.
module tb_alu_dispatch;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [3:0]  out_op;
  logic        out_illegal;
  logic [2:0]  out_funct3;
  logic [15:0] issue_count;

  alu_dispatch dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_op(out_op),
    .out_illegal(out_illegal), .out_funct3(out_funct3),
    .issue_count(issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        ill;
    logic [2:0]  f3;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode written from the instruction-set rules, one mnemonic group at a time.
  function automatic exp_t ref_dec(input logic [31:0] w, input logic [31:0] pc,
                                   input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    int   rtab[8] = '{0, 5, 8, 9, 4, 6, 3, 2};
    int   btab[8] = '{1, 1, 15, 15, 8, 8, 9, 9};
    int   op;
    logic [6:0] opc;
    logic [6:0] f7;
    int   f3;
    logic [31:0] ii;
    logic [31:0] si;
    opc = w[6:0];
    f7  = w[31:25];
    f3  = int'(w[14:12]);
    ii  = 32'($signed(w[31:20]));
    si  = 32'($signed({w[31:25], w[11:7]}));
    e.f3 = w[14:12];
    e.a = 0; e.b = 0; op = 15;
    if (opc == 7'h33) begin
      e.a = r1; e.b = r2;
      if (f7 == 0) op = rtab[f3];
      else if (f7 == 7'h20 && f3 == 0) op = 1;
      else if (f7 == 7'h20 && f3 == 5) op = 7;
    end else if (opc == 7'h13) begin
      e.a = r1; e.b = ii;
      if (f3 == 1) op = (f7 == 0) ? 5 : 15;
      else if (f3 == 5) op = (f7 == 0) ? 6 : (f7 == 7'h20) ? 7 : 15;
      else op = rtab[f3];
    end else if (opc == 7'h63) begin
      e.a = r1; e.b = r2; op = btab[f3];
    end else if (opc == 7'h03) begin
      e.a = r1; e.b = ii; op = 0;
    end else if (opc == 7'h23) begin
      e.a = r1; e.b = si; op = 0;
    end else if (opc == 7'h37) begin
      e.a = 0; e.b = {w[31:12], 12'h0}; op = 0;
    end else if (opc == 7'h17) begin
      e.a = pc; e.b = {w[31:12], 12'h0}; op = 0;
    end
    if (op == 15) begin
      e.a = 0; e.b = 0;
    end
    e.op  = 4'(op);
    e.ill = (op == 15);
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    int k;
    int j;
    w = $urandom;
    k = $urandom_range(0, 9);
    j = $urandom_range(0, 3);
    case (k)
      0, 1: w[6:0] = 7'h33;
      2, 3: w[6:0] = 7'h13;
      4:    w[6:0] = 7'h63;
      5:    w[6:0] = 7'h03;
      6:    w[6:0] = 7'h23;
      7:    w[6:0] = 7'h37;
      8:    w[6:0] = 7'h17;
      default: ;
    endcase
    if (j == 0) w[31:25] = 7'h00;
    else if (j == 1) w[31:25] = 7'h20;
    return w;
  endfunction

  // Scoreboard monitor: sampled on the falling edge, reflecting what the next rising edge will do.
  logic        armed;
  logic        hold;
  exp_t        held;
  logic [15:0] mcnt;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) armed <= 1'b0;
    else armed <= 1'b1;

  initial begin
    hold = 1'b0;
    mcnt = '0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      mcnt = '0;
      hold = 1'b0;
      chk("rst_count", 32'(issue_count), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'h0);
    end else begin
      chk("issue_count", 32'(issue_count), 32'(mcnt));
      if (armed) begin
        chk("in_ready_vs_occupancy", 32'(in_ready), 32'(sb.size() < 2));
        chk("out_valid_vs_occupancy", 32'(out_valid), 32'(sb.size() > 0));
      end
      if (hold) begin
        chk("hold_a", out_a, held.a);
        chk("hold_b", out_b, held.b);
        chk("hold_op", 32'(out_op), 32'(held.op));
        chk("hold_funct3", 32'(out_funct3), 32'(held.f3));
      end
      hold = out_valid && !out_ready && !flush;
      held.a = out_a; held.b = out_b; held.op = out_op; held.f3 = out_funct3;
      held.ill = out_illegal;
      if (flush) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_output", 32'(sb.size()), 32'h1);
          end else begin
            e = sb.pop_front();
            chk("out_a", out_a, e.a);
            chk("out_b", out_b, e.b);
            chk("out_op", 32'(out_op), 32'(e.op));
            chk("out_illegal", 32'(out_illegal), 32'(e.ill));
            chk("out_funct3", 32'(out_funct3), 32'(e.f3));
          end
          mcnt = mcnt + 16'd1;
        end
        if (in_valid && in_ready)
          sb.push_back(ref_dec(in_instr, in_pc, in_rs1, in_rs2));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] w, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2);
    in_valid = 1'b1; in_instr = w; in_pc = pc; in_rs1 = r1; in_rs2 = r2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  logic [15:0] c0;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0; in_rs1 = '0; in_rs2 = '0;
    #3;
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_in_ready", 32'(in_ready), 32'h0);
    chk("reset_out_a", out_a, 32'h0);
    chk("reset_out_op", 32'(out_op), 32'h0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("in_ready_after_reset", 32'(in_ready), 32'h1);

    // sub x10,x10,x11
    out_ready = 1'b1;
    drive(32'h40B50533, 32'h0, 32'd5, 32'd3);
    step();
    in_valid = 1'b0;
    chk("sub_valid", 32'(out_valid), 32'h1);
    chk("sub_op", 32'(out_op), 32'd1);
    chk("sub_a", out_a, 32'd5);
    chk("sub_b", out_b, 32'd3);
    chk("sub_illegal", 32'(out_illegal), 32'h0);
    step();

    // addi x1,x1,-1 then auipc x5,0x12345
    drive(32'hFFF08093, 32'h0, 32'd1, 32'd0);
    step();
    chk("addi_op", 32'(out_op), 32'd0);
    chk("addi_b", out_b, 32'hFFFFFFFF);
    drive(32'h12345297, 32'h100, 32'd7, 32'd9);
    step();
    in_valid = 1'b0;
    chk("auipc_a", out_a, 32'h100);
    chk("auipc_b", out_b, 32'h12345000);
    step();

    // Backpressure: three offered, two accepted
    out_ready = 1'b0;
    c0 = issue_count;
    drive(32'h00B50533, 32'h0, 32'd10, 32'd20);
    step();
    drive(32'h00B57533, 32'h0, 32'hF0F0, 32'hFF00);
    step();
    chk("bp_in_ready_low", 32'(in_ready), 32'h0);
    drive(32'h00B56533, 32'h0, 32'd1, 32'd2);
    step();
    in_valid = 1'b0;
    chk("bp_still_low", 32'(in_ready), 32'h0);
    chk("bp_first_held", out_a, 32'd10);
    out_ready = 1'b1;
    step();
    chk("bp_in_ready_back", 32'(in_ready), 32'h1);
    step();
    step();
    chk("bp_count", 32'(issue_count), 32'(c0 + 16'd2));
    chk("bp_drained", 32'(out_valid), 32'h0);

    // Illegal encodings
    c0 = issue_count;
    drive(32'h0000007F, 32'h0, 32'd3, 32'd4);
    step();
    chk("ill7f_op", 32'(out_op), 32'd15);
    chk("ill7f_flag", 32'(out_illegal), 32'h1);
    drive(32'h40109093, 32'h0, 32'd3, 32'd4);
    step();
    in_valid = 1'b0;
    chk("illslli_op", 32'(out_op), 32'd15);
    chk("illslli_flag", 32'(out_illegal), 32'h1);
    step();
    chk("ill_count", 32'(issue_count), 32'(c0 + 16'd2));

    // Flush with both entries full, concurrent input and output handshake
    out_ready = 1'b0;
    drive(gen_instr(), $urandom, $urandom, $urandom);
    step();
    drive(gen_instr(), $urandom, $urandom, $urandom);
    step();
    c0 = issue_count;
    out_ready = 1'b1;
    drive(gen_instr(), $urandom, $urandom, $urandom);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'h0);
    chk("flush_in_ready", 32'(in_ready), 32'h1);
    chk("flush_count", 32'(issue_count), 32'(c0));
    step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = gen_instr();
      in_pc     = $urandom;
      in_rs1    = $urandom;
      in_rs2    = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    step();
    step();
    chk("random_drained", 32'(out_valid), 32'h0);

    // Reset asserted mid-stall
    out_ready = 1'b0;
    drive(gen_instr(), $urandom, $urandom, $urandom);
    step();
    drive(gen_instr(), $urandom, $urandom, $urandom);
    step();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'h0);
    chk("async_in_ready", 32'(in_ready), 32'h0);
    chk("async_count", 32'(issue_count), 32'h0);
    chk("async_a", out_a, 32'h0);
    chk("async_b", out_b, 32'h0);
    chk("async_op", 32'(out_op), 32'h0);
    chk("async_illegal", 32'(out_illegal), 32'h0);
    chk("async_funct3", 32'(out_funct3), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", 32'(in_ready), 32'h1);
    out_ready = 1'b1;
    step();
    chk("post_rst_discarded", 32'(out_valid), 32'h0);

    // Counter wrap
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      drive(32'h00108093, 32'h0, 32'(i), 32'h0);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("count_ffff", 32'(issue_count), 32'h0000FFFF);
    drive(32'h00108093, 32'h0, 32'h1, 32'h0);
    step();
    in_valid = 1'b0;
    step();
    chk("count_wrap", 32'(issue_count), 32'h0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_dispatch.md
ALU_DISPATCH -- requirements
Module: alu_dispatch

Interface
REQ-001 clk  input  1  rising-edge clock; sole clock of the block.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 flush  input  1  synchronous discard of all buffered entries.
REQ-004 in_valid / in_ready  input / output  1 / 1  upstream handshake; a transfer occurs on a clk edge with both high.
REQ-005 in_instr, in_pc, in_rs1, in_rs2  input  32 each  RV32I instruction word, its PC, and the source-register values.
REQ-006 out_valid / out_ready  output / input  1 / 1  downstream (ALU side) handshake.
REQ-007 out_a, out_b  output  32 each  ALU operands.
REQ-008 out_op  output  4  ALU op code: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu, 15 illegal marker.
REQ-009 out_illegal  output  1  entry was not a decodable ALU-using instruction.
REQ-010 out_funct3  output  3  instr[14:12], passed through for branch resolution.
REQ-011 issue_count  output  16  count of completed output transfers.

Function
REQ-012 Decode: opcode 0110011 (R) SHALL map funct3/funct7 to add/sub/sll/slt/sltu/xor/srl/sra/or/and, with a=rs1 and b=rs2; funct7 values other than 0000000, or 0100000 on funct3 000/101, SHALL be illegal.
REQ-013 Opcode 0010011 (I-ALU) SHALL use a=rs1 and b=sign-extended instr[31:20]; slli requires funct7 0000000; srli/srai are selected by funct7 0000000/0100000; any other funct7 on a shift is illegal.
REQ-014 Opcode 1100011 (branch): beq/bne SHALL map to sub, blt/bge to slt, bltu/bgeu to sltu, with a=rs1 and b=rs2; funct3 010/011 is illegal.
REQ-015 Opcodes 0000011 (load) and 0100011 (store) SHALL map to add with a=rs1; b is the sign-extended I-immediate for loads and the S-immediate for stores.
REQ-016 LUI SHALL map to add with a=0 and b={instr[31:12],12'h0}; AUIPC SHALL map to add with a=pc and the same b.
REQ-017 Any other opcode SHALL produce op=15, a=0, b=0, illegal=1; an illegal entry still transfers and is counted.
REQ-018 Buffering: 2-entry skid buffer (output register plus skid register); latency from input transfer to out_valid SHALL be exactly 1 cycle when the output stage is empty or draining.
REQ-019 in_ready SHALL be the registered inverse of skid-full; it SHALL depend on no input combinationally.
REQ-020 If an input transfers while the output stage is held (out_valid=1, out_ready=0), the entry SHALL go to the skid register and in_ready SHALL be 0 the next cycle.
REQ-021 On an output transfer with the skid register full, the skid entry SHALL move to the output stage on the same edge, and in_ready SHALL return to 1 the next cycle.
REQ-022 Output fields SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 Entries SHALL leave in acceptance order, never duplicated or dropped.
REQ-024 flush SHALL, at the next edge, clear out_valid and the skid register and ignore any same-cycle input transfer; issue_count SHALL NOT change, and SHALL NOT count an output handshake in the flush cycle.
REQ-025 issue_count SHALL increment on each output transfer and wrap from FFFF to 0000.

Reset
REQ-026 On rst_n low: out_valid=0, skid empty, in_ready=0, issue_count=0, out_a=0, out_b=0, out_op=0, out_illegal=0, out_funct3=0, taking effect immediately without a clock edge.
REQ-027 in_ready SHALL rise on the first clk edge after rst_n deasserts; a reset asserted mid-stall SHALL discard both entries.

Verification
REQ-028 Basic decode: instr 0x40B50533 (sub x10,x10,x11), rs1=5, rs2=3, out_ready=1 -> next cycle out_valid=1, op=1, a=5, b=3, illegal=0.
REQ-029 Immediate and U-type: addi with imm=0xFFF, rs1=1 -> op=0, b=0xFFFFFFFF; AUIPC imm 0x12345 at pc=0x100 -> a=0x100, b=0x12345000.
REQ-030 Backpressure: hold out_ready=0 and push 3 instructions -> 2 accepted, in_ready=0 from the cycle after the 2nd; release out_ready -> both emerge in order and issue_count=2.
REQ-031 Illegal encodings: opcode 0x7F, and slli with funct7=0100000 -> op=15, illegal=1, issue_count increments.
REQ-032 Flush: flush with both entries full -> next cycle out_valid=0, in_ready=1, issue_count unchanged.
REQ-033 Reset and wrap: preload issue_count to 0xFFFF via 65535 transfers, then one more transfer -> 0x0000; assert rst_n low mid-stall -> all outputs at reset values with no clock edge.
